// File: rtl/mem_pkg.sv
// Shared types and widths for the memory-access stage.
// Holds the FSM state enum and the MEM/WB payload struct.
package mem_pkg;
    localparam int WORD_W    = 32;
    localparam int REG_NUM_W = 5;
    localparam int TO_CNT_W  = 8;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic                 reg_write;
        logic [REG_NUM_W-1:0] rd_num;
        logic [WORD_W-1:0]    wb_data;
    } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with bubble insert and error-flag capture.
// Latency: 1 cycle. Backpressure: none; loads every cycle, bubble zeroes the payload.
// Flags: error/misalign pulses travel only with a bubble.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble,
    input  logic    bus_error,
    input  logic    misalign,
    input  mem_wb_t d,
    output mem_wb_t q,
    output logic    bus_error_q,
    output logic    misalign_q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q           <= '0;
            bus_error_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (bubble) begin
            q           <= '0;
            bus_error_q <= bus_error;
            misalign_q  <= misalign;
        end else begin
            q           <= d;
            bus_error_q <= 1'b0;
            misalign_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: load/store over a req/ack data-memory port with timeout abort.
// Latency: 1 cycle to MEM/WB after completion; Backpressure: stall held while an access waits for ack.
// Optional MEM_STAGE_ALIGN_CHECK_EN rejects misaligned word accesses without issuing a request.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_write_en,
    input  logic                 mem_to_reg,
    input  logic                 reg_write,
    input  logic [WORD_W-1:0]    alu_result,
    input  logic [WORD_W-1:0]    read_data_2,
    input  logic [REG_NUM_W-1:0] rd_num,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [WORD_W-1:0]    dmem_addr,
    output logic [WORD_W-1:0]    dmem_wdata,
    input  logic [WORD_W-1:0]    dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 stall,
    output logic                 reg_write_out,
    output logic [REG_NUM_W-1:0] rd_num_out,
    output logic [WORD_W-1:0]    wb_data_out,
    output logic                 bus_error_out,
    output logic                 misalign_out
);
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

    mem_state_t          state, state_next;
    logic [TO_CNT_W-1:0] cnt, cnt_next;
    logic                mem_op, is_load, misalign, access, complete, abort, bubble;
    mem_wb_t             wb_d, wb_q;

    assign mem_op  = mem_write_en | mem_to_reg;
    assign is_load = mem_to_reg & ~mem_write_en;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misalign = ~rst && (state == IDLE) && mem_op && (alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Upstream is frozen during WAIT, so the held inputs still describe the access.
    assign access   = ~rst && ((state == WAIT) || (mem_op && ~misalign));
    assign complete = access && dmem_ack;
    assign abort    = ~rst && (state == WAIT) && (cnt == TO_LIMIT) && ~dmem_ack;
    assign stall    = access && ~complete && ~abort;

    assign dmem_req   = access;
    assign dmem_we    = mem_write_en;
    assign dmem_addr  = alu_result;
    assign dmem_wdata = read_data_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (access && ~dmem_ack) begin
                    state_next = WAIT;
                    cnt_next   = TO_CNT_W'(1);
                end
            end
            WAIT: begin
                if (complete || abort) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + TO_CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Only a completed load or a non-memory op carries a payload; everything else is a bubble.
    assign bubble = access ? ~(complete && is_load) : misalign;

    always_comb begin
        wb_d           = '0;
        wb_d.reg_write = reg_write & ~mem_write_en;
        wb_d.rd_num    = rd_num;
        wb_d.wb_data   = mem_to_reg ? dmem_rdata : alu_result;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .bubble      (bubble),
        .bus_error   (abort),
        .misalign    (misalign),
        .d           (wb_d),
        .q           (wb_q),
        .bus_error_q (bus_error_out),
        .misalign_q  (misalign_out)
    );

    assign reg_write_out = wb_q.reg_write;
    assign rd_num_out    = wb_q.rd_num;
    assign wb_data_out   = wb_q.wb_data;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver pushes expected MEM/WB results, a monitor pops and compares.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write_en, mem_to_reg, reg_write;
    logic [31:0] alu_result, read_data_2;
    logic [4:0]  rd_num;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall, reg_write_out, bus_error_out, misalign_out;
    logic [4:0]  rd_num_out;
    logic [31:0] wb_data_out;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic        be;
        logic        ma;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic tb_active = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_write_en  (mem_write_en),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_result    (alu_result),
        .read_data_2   (read_data_2),
        .rd_num        (rd_num),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .reg_write_out (reg_write_out),
        .rd_num_out    (rd_num_out),
        .wb_data_out   (wb_data_out),
        .bus_error_out (bus_error_out),
        .misalign_out  (misalign_out)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    endtask

    function automatic exp_t mk(input logic rw, input logic [4:0] rd, input logic [31:0] wb,
                                input logic be, input logic ma);
        exp_t e;
        e.rw = rw; e.rd = rd; e.wb = wb; e.be = be; e.ma = ma;
        return e;
    endfunction

    // Monitor: a non-stalled presented cycle delivers one result; stalled cycles must yield bubbles.
    initial begin
        exp_t e;
        logic deliver, active;
        forever begin
            @(negedge clk);
            #3;
            active  = tb_active;
            deliver = tb_active && !stall;
            @(posedge clk);
            #1;
            if (deliver) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_reg_write", 64'(reg_write_out), 64'(e.rw));
                    check("wb_rd_num",    64'(rd_num_out),    64'(e.rd));
                    check("wb_data",      64'(wb_data_out),   64'(e.wb));
                    check("wb_bus_error", 64'(bus_error_out), 64'(e.be));
                    check("wb_misalign",  64'(misalign_out),  64'(e.ma));
                end
            end else if (active) begin
                check("stall_bubble", {reg_write_out, rd_num_out, wb_data_out, bus_error_out},
                      64'd0);
            end
        end
    end

    // ack_at: cycle index (0 = issue cycle) at which ack is raised; -1 = never.
    task automatic run_op(input string name, input logic we, input logic ld, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int ack_at, input logic [31:0] rdata,
                          input int exp_stalls, input int exp_reqs, input exp_t e);
        int  c = 0;
        int  stalls = 0;
        int  reqs = 0;
        bit  done = 0;
        bit  bad_bus = 0;
        logic s;
        @(negedge clk);
        mem_write_en = we; mem_to_reg = ld; reg_write = rw;
        alu_result = addr; read_data_2 = wdata; rd_num = rd;
        dmem_rdata = rdata;
        tb_active = 1'b1;
        exp_q.push_back(e);
        while (!done && c < 40) begin
            dmem_ack = (c == ack_at);
            #2;
            if (dmem_req) begin
                reqs++;
                if (dmem_we !== we || dmem_addr !== addr || dmem_wdata !== wdata) bad_bus = 1;
            end
            s = stall;
            if (s) stalls++;
            @(posedge clk);
            c++;
            if (!s) done = 1;
            else @(negedge clk);
        end
        check({name, "_done"},   64'(done),    64'd1);
        check({name, "_stalls"}, 64'(stalls),  64'(exp_stalls));
        check({name, "_reqs"},   64'(reqs),    64'(exp_reqs));
        check({name, "_bus"},    64'(bad_bus), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_write_en = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
        alu_result = 32'h100; read_data_2 = 32'h5; rd_num = 5'd3;
        dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_req",   64'(dmem_req), 64'd0);
        check("rst_stall", 64'(stall),    64'd0);
        check("rst_outs", {reg_write_out, rd_num_out, wb_data_out, bus_error_out, misalign_out},
              64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_write_en = 1'b0; mem_to_reg = 1'b0;

        run_op("alu", 0, 0, 1, 32'h1234, 32'h0, 5'd5, -1, 32'h0, 0, 0,
               mk(1, 5'd5, 32'h1234, 0, 0));
        run_op("load0ws", 0, 1, 1, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF, 0, 1,
               mk(1, 5'd3, 32'hDEADBEEF, 0, 0));
        run_op("store3ws", 1, 0, 1, 32'h200, 32'hCAFE, 5'd7, 3, 32'h0, 3, 4,
               mk(0, 5'd0, 32'h0, 0, 0));
        run_op("load_timeout", 0, 1, 1, 32'h300, 32'h0, 5'd9, -1, 32'h11, 4, 5,
               mk(0, 5'd0, 32'h0, 1, 0));
        run_op("alu_after_abort", 0, 0, 0, 32'h55, 32'h0, 5'd9, -1, 32'h0, 0, 0,
               mk(0, 5'd9, 32'h55, 0, 0));
        run_op("load_ack_at_limit", 0, 1, 1, 32'h304, 32'h0, 5'd10, 4, 32'h12345678, 4, 5,
               mk(1, 5'd10, 32'h12345678, 0, 0));
        run_op("store_and_load", 1, 1, 1, 32'h400, 32'hBEEF, 5'd4, 1, 32'hFFFF, 1, 2,
               mk(0, 5'd0, 32'h0, 0, 0));
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        run_op("misalign", 0, 1, 1, 32'h102, 32'h0, 5'd6, 0, 32'hAAAA5555, 0, 0,
               mk(0, 5'd0, 32'h0, 0, 1));
`else
        run_op("unaligned_ok", 0, 1, 1, 32'h102, 32'h0, 5'd6, 0, 32'hAAAA5555, 0, 1,
               mk(1, 5'd6, 32'hAAAA5555, 0, 0));
`endif

        // Reset during WAIT, then a late ack while idle.
        @(negedge clk);
        tb_active = 1'b0;
        mem_write_en = 1'b0; mem_to_reg = 1'b1; reg_write = 1'b1;
        alu_result = 32'h500; rd_num = 5'd8; dmem_ack = 1'b0; dmem_rdata = 32'h77;
        repeat (3) @(negedge clk);
        #2;
        check("wait_req_held", 64'(dmem_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rst_wait_req",   64'(dmem_req), 64'd0);
        check("rst_wait_stall", 64'(stall),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_to_reg = 1'b0; reg_write = 1'b0; alu_result = 32'h0; rd_num = 5'd0;
        dmem_ack = 1'b1;
        #2;
        check("late_ack_req",   64'(dmem_req), 64'd0);
        check("late_ack_stall", 64'(stall),    64'd0);
        @(posedge clk);
        #1;
        check("late_ack_outs", {reg_write_out, rd_num_out, wb_data_out, bus_error_out}, 64'd0);
        dmem_ack = 1'b0;

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
